// File: rtl/dma_controller_pkg.sv
// Shared definitions for the OAM DMA controller.
//   dma_state_e   : FSM state encoding (2 bits)
//   DMA_LEN_DEF   : default bytes per transfer
//   DST_BASE_DEF  : default OAM destination base address
//   REG_ADDR_DEF  : CPU address of the DMA source register
package dma_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } dma_state_e;

  localparam int          DMA_LEN_DEF  = 160;
  localparam logic [15:0] DST_BASE_DEF = 16'hFE00;
  localparam logic [15:0] REG_ADDR_DEF = 16'hFF46;

endpackage

// File: rtl/dma_controller.sv
// OAM DMA controller. A CPU write of the source page register starts (or
// restarts) a copy of DMA_LEN bytes from {src_hi, 8'h00} to DST_BASE,
// alternating one READ cycle and one WRITE cycle per byte.
//
// Build option: define DMA_CPU_STALL_EN to hold cpu_wait_n low for the
// whole transfer; otherwise cpu_wait_n is tied high.
//
// Ports
//   clock, reset          : system clock, async active-high reset
//   A, Di, Do             : CPU register bus (address, write data, read data)
//   cs, rd_n, wr_n        : register chip select and CPU strobes (active-low)
//   A_dma, Do_dma, Di_dma : DMA bus address, write data, read data
//   rd_dma_n, wr_dma_n    : DMA bus strobes (active-low)
//   dma_active            : DMA bus grant, high whenever the FSM is not idle
//   cpu_wait_n            : CPU stall request (active-low)
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | no transfer, DMA strobes released
// READ   | rd_dma_n low at {src_hi, idx}; byte latched at end
// WRITE  | wr_dma_n low at DST_BASE + idx; idx advances at end
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int          DMA_LEN  = DMA_LEN_DEF,
  parameter logic [15:0] DST_BASE = DST_BASE_DEF,
  parameter logic [15:0] REG_ADDR = REG_ADDR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  Di,
  output logic [7:0]  Do,
  input  logic        cs,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [15:0] A_dma,
  output logic [7:0]  Do_dma,
  input  logic [7:0]  Di_dma,
  output logic        rd_dma_n,
  output logic        wr_dma_n,
  output logic        dma_active,
  output logic        cpu_wait_n
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_e  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  latch_q, latch_d;
  logic [15:0] a_dma_q, a_dma_d;
  logic [7:0]  do_dma_q, do_dma_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        active_q, active_d;

  logic reg_hit, reg_wr, reg_rd;

  always_comb begin
    reg_hit = cs && (A == REG_ADDR);
    reg_wr  = reg_hit && !wr_n;
    reg_rd  = reg_hit && !rd_n;
    Do      = reg_rd ? src_q : 8'hFF;
  end

  // Next state. A register write always wins, including on the final WRITE
  // cycle, so a late write is a clean restart rather than being dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    latch_d = latch_q;
    if (reg_wr) begin
      src_d   = Di;
      idx_d   = 8'h00;
      state_d = ST_READ;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_READ: begin
          latch_d = Di_dma;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_READ;
          end else begin
            idx_d   = 8'h00;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from the next state so they are registered yet
  // line up with the cycle the state register is in.
  always_comb begin
    a_dma_d  = 16'h0000;
    do_dma_d = 8'h00;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    case (state_d)
      ST_READ: begin
        a_dma_d = {src_d, idx_d};
        rd_n_d  = 1'b0;
      end
      ST_WRITE: begin
        a_dma_d  = DST_BASE + {8'h00, idx_d};
        do_dma_d = latch_d;
        wr_n_d   = 1'b0;
      end
      default: ;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 8'h00;
      src_q    <= 8'h00;
      latch_q  <= 8'h00;
      a_dma_q  <= 16'h0000;
      do_dma_q <= 8'h00;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      src_q    <= src_d;
      latch_q  <= latch_d;
      a_dma_q  <= a_dma_d;
      do_dma_q <= do_dma_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      active_q <= active_d;
    end
  end

  assign A_dma      = a_dma_q;
  assign Do_dma     = do_dma_q;
  assign rd_dma_n   = rd_n_q;
  assign wr_dma_n   = wr_n_q;
  assign dma_active = active_q;

`ifdef DMA_CPU_STALL_EN
  assign cpu_wait_n = ~active_q;
`else
  assign cpu_wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_dma_controller.sv
// Self-checking bench for dma_controller: a memory model on the DMA bus, and
// a per-cycle expected bus trace derived from the transfer rules
// (cycle 2i reads {page,i}, cycle 2i+1 writes FE00+i with source byte i).
module tb_dma_controller;

  localparam int LEN = 160;
`ifdef DMA_CPU_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [7:0]  Di;
  logic [7:0]  Do;
  logic        cs, rd_n, wr_n;
  logic [15:0] A_dma;
  logic [7:0]  Do_dma;
  logic [7:0]  Di_dma;
  logic        rd_dma_n, wr_dma_n, dma_active, cpu_wait_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] src_mem [0:65535];
  logic [7:0] dst_mem [0:65535];
  logic [7:0] ref_src [0:255];

  dma_controller dut (
    .clock      (clock),
    .reset      (reset),
    .A          (A),
    .Di         (Di),
    .Do         (Do),
    .cs         (cs),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .A_dma      (A_dma),
    .Do_dma     (Do_dma),
    .Di_dma     (Di_dma),
    .rd_dma_n   (rd_dma_n),
    .wr_dma_n   (wr_dma_n),
    .dma_active (dma_active),
    .cpu_wait_n (cpu_wait_n)
  );

  always #5 clock = ~clock;

  assign Di_dma = src_mem[A_dma];
  always @(posedge clock) if (!wr_dma_n) dst_mem[A_dma] <= Do_dma;

  // {active, rd_n, wr_n, wait_n, addr, data}; cycle k counted from the first
  // cycle after the register write.
  function automatic logic [27:0] model_bus(input logic [7:0] page, input int k);
    logic wait_act;
    int   i;
    wait_act = STALL ? 1'b0 : 1'b1;
    if (k >= 2 * LEN) return {1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00};
    i = k / 2;
    if (k % 2 == 0) return {1'b1, 1'b0, 1'b1, wait_act, page, 8'(i), 8'h00};
    return {1'b1, 1'b1, 1'b0, wait_act, 16'hFE00 + 16'(i), ref_src[i]};
  endfunction

  // Address only meaningful while a strobe is low, data only while writing.
  function automatic logic [27:0] obs_bus();
    return {dma_active, rd_dma_n, wr_dma_n, cpu_wait_n,
            (rd_dma_n && wr_dma_n) ? 16'h0000 : A_dma,
            wr_dma_n ? 8'h00 : Do_dma};
  endfunction

  task automatic do_write(input logic [7:0] v);
    @(negedge clock);
    cs = 1'b1; wr_n = 1'b0; A = 16'hFF46; Di = v;
    @(posedge clock);
    #1;
    cs = 1'b0; wr_n = 1'b1; A = 16'h0000;
  endtask

  task automatic fill_page(input logic [7:0] page);
    for (int i = 0; i < 256; i++) src_mem[{page, 8'(i)}] = 8'($urandom);
  endtask

  task automatic load_ref(input logic [7:0] page);
    for (int i = 0; i < 256; i++) ref_src[i] = src_mem[{page, 8'(i)}];
  endtask

  task automatic test_reset();
    logic [27:0] exp_v;
    exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00};
    #1 reset = 1'b1;
    #2;
    n_cmp++;
    if ({dma_active, rd_dma_n, wr_dma_n, cpu_wait_n, A_dma, Do_dma} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=%h",
               {dma_active, rd_dma_n, wr_dma_n, cpu_wait_n, A_dma, Do_dma}, exp_v);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    cs = 1'b1; rd_n = 1'b0; A = 16'hFF46;
    #1;
    n_cmp++;
    if (Do !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_src_read got=%h exp=00", Do);
    end
    cs = 1'b0; rd_n = 1'b1; A = 16'h0000;
  endtask

  task automatic test_first_transfer();
    logic [27:0] exp_v, obs_v;
    int stall_cnt;
    for (int i = 0; i < 256; i++) src_mem[{8'hC1, 8'(i)}] = 8'(i) ^ 8'h5A;
    load_ref(8'hC1);
    do_write(8'hC1);
    stall_cnt = 0;
    for (int k = 0; k < 2 * LEN + 6; k++) begin
      @(negedge clock);
      exp_v = model_bus(8'hC1, k);
      obs_v = obs_bus();
      if (!cpu_wait_n) stall_cnt++;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL first_bus k=%0d got=%h exp=%h", k, obs_v, exp_v);
      end
    end
    n_cmp++;
    if (stall_cnt !== (STALL ? 2 * LEN : 0)) begin
      n_fail++;
      $display("FAIL stall_cycles got=%0d exp=%0d", stall_cnt, STALL ? 2 * LEN : 0);
    end
    for (int i = 0; i < LEN; i++) begin
      n_cmp++;
      if (dst_mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) begin
        n_fail++;
        $display("FAIL first_oam i=%0d got=%h exp=%h",
                 i, dst_mem[16'hFE00 + 16'(i)], 8'(i) ^ 8'h5A);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] exp_v, obs_v;
    logic [7:0]  pages [3];
    pages[0] = 8'h12;
    pages[1] = 8'hE5;
    pages[2] = 8'($urandom_range(8'h20, 8'hBF));
    for (int r = 0; r < 3; r++) begin
      fill_page(pages[r]);
      load_ref(pages[r]);
      do_write(pages[r]);
      for (int k = 0; k <= 2 * LEN; k++) begin
        @(negedge clock);
        exp_v = model_bus(pages[r], k);
        obs_v = obs_bus();
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_fail++;
          $display("FAIL b2b_bus page=%h k=%0d got=%h exp=%h", pages[r], k, obs_v, exp_v);
        end
      end
      for (int i = 0; i < LEN; i++) begin
        n_cmp++;
        if (dst_mem[16'hFE00 + 16'(i)] !== ref_src[i]) begin
          n_fail++;
          $display("FAIL b2b_oam page=%h i=%0d got=%h exp=%h",
                   pages[r], i, dst_mem[16'hFE00 + 16'(i)], ref_src[i]);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic [27:0] exp_v, obs_v;
    fill_page(8'hC1);
    load_ref(8'hC1);
    do_write(8'hC1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      exp_v = model_bus(8'hC1, k);
      obs_v = obs_bus();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL restart_pre k=%0d got=%h exp=%h", k, obs_v, exp_v);
      end
    end
    fill_page(8'hD0);
    load_ref(8'hD0);
    do_write(8'hD0);
    for (int k = 0; k < 2 * LEN + 3; k++) begin
      @(negedge clock);
      exp_v = model_bus(8'hD0, k);
      obs_v = obs_bus();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL restart_bus k=%0d got=%h exp=%h", k, obs_v, exp_v);
      end
    end
    for (int i = 0; i < LEN; i++) begin
      n_cmp++;
      if (dst_mem[16'hFE00 + 16'(i)] !== ref_src[i]) begin
        n_fail++;
        $display("FAIL restart_oam i=%0d got=%h exp=%h", i, dst_mem[16'hFE00 + 16'(i)], ref_src[i]);
      end
    end
  endtask

  // Second write lands on the same edge as the last WRITE cycle of the first.
  task automatic test_restart_at_end();
    logic [27:0] exp_v, obs_v;
    fill_page(8'h40);
    fill_page(8'h41);
    load_ref(8'h40);
    do_write(8'h40);
    for (int k = 0; k < 2 * LEN - 1; k++) begin
      @(negedge clock);
      exp_v = model_bus(8'h40, k);
      obs_v = obs_bus();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL end_restart_pre k=%0d got=%h exp=%h", k, obs_v, exp_v);
      end
    end
    load_ref(8'h41);
    do_write(8'h41);
    for (int k = 0; k <= 2 * LEN; k++) begin
      @(negedge clock);
      exp_v = model_bus(8'h41, k);
      obs_v = obs_bus();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL end_restart_bus k=%0d got=%h exp=%h", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [27:0] exp_v, obs_v;
    fill_page(8'h77);
    load_ref(8'h77);
    do_write(8'h77);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      exp_v = model_bus(8'h77, k);
      obs_v = obs_bus();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_pre k=%0d got=%h exp=%h", k, obs_v, exp_v);
      end
    end
    #2 reset = 1'b1;
    #1;
    exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00};
    n_cmp++;
    if ({dma_active, rd_dma_n, wr_dma_n, cpu_wait_n, A_dma, Do_dma} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%h exp=%h",
               {dma_active, rd_dma_n, wr_dma_n, cpu_wait_n, A_dma, Do_dma}, exp_v);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      exp_v = model_bus(8'h77, 2 * LEN);
      obs_v = obs_bus();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_idle k=%0d got=%h exp=%h", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_readback();
    logic [27:0] exp_v, obs_v;
    fill_page(8'h80);
    load_ref(8'h80);
    do_write(8'h80);
    for (int k = 0; k <= 2 * LEN + 1; k++) begin
      @(negedge clock);
      exp_v = model_bus(8'h80, k);
      obs_v = obs_bus();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL readback_bus k=%0d got=%h exp=%h", k, obs_v, exp_v);
      end
      if (k == 10) begin
        cs = 1'b1; rd_n = 1'b0; A = 16'hFF46;
        #1;
        n_cmp++;
        if (Do !== 8'h80) begin
          n_fail++;
          $display("FAIL read_ff46 got=%h exp=80", Do);
        end
      end else if (k == 11) begin
        A = 16'hFF45;
        #1;
        n_cmp++;
        if (Do !== 8'hFF) begin
          n_fail++;
          $display("FAIL read_ff45 got=%h exp=ff", Do);
        end
      end else if (k == 12) begin
        cs = 1'b0; A = 16'hFF46;
        #1;
        n_cmp++;
        if (Do !== 8'hFF) begin
          n_fail++;
          $display("FAIL read_no_cs got=%h exp=ff", Do);
        end
        rd_n = 1'b1; A = 16'h0000;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    cs    = 1'b0;
    rd_n  = 1'b1;
    wr_n  = 1'b1;
    A     = 16'h0000;
    Di    = 8'h00;
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    test_reset();
    test_first_transfer();
    test_back_to_back();
    test_restart();
    test_restart_at_end();
    test_reset_mid();
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 Parameter: DMA_LEN, 160, number of bytes per transfer.
REQ-002 Parameter: DST_BASE, 16'hFE00, OAM destination base address.
REQ-003 Parameter: REG_ADDR, 16'hFF46, address of the DMA source register.
REQ-004 Port: clock  in  1  system clock; the only clock.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: A  in  16  CPU-side bus address for register decode.
REQ-007 Port: Di  in  8  CPU write data.
REQ-008 Port: Do  out  8  register read data.
REQ-009 Port: cs  in  1  register chip select from the memory controller.
REQ-010 Port: rd_n / wr_n  in  1 each  CPU bus strobes, active-low.
REQ-011 Port: A_dma  out  16  DMA bus address.
REQ-012 Port: Do_dma  out  8  DMA write data.
REQ-013 Port: Di_dma  in  8  DMA read data.
REQ-014 Port: rd_dma_n / wr_dma_n  out  1 each  DMA bus strobes, active-low.
REQ-015 Port: dma_active  out  1  bus grant; the memory controller muxes the DMA bus over the CPU bus while it is high.
REQ-016 Port: cpu_wait_n  out  1  CPU stall request, active-low.

Function
REQ-017 Register write: cs high, wr_n low and A==REG_ADDR at a rising clock edge -> src_hi <= Di.
- Same edge starts a transfer from the next cycle.
REQ-018 Register read: cs high, rd_n low and A==REG_ADDR -> Do = src_hi (combinational); otherwise Do = 8'hFF.
REQ-019 FSM states: IDLE, READ, WRITE.
- IDLE -> READ on register write.
- READ -> WRITE after one cycle.
- WRITE -> READ if idx < DMA_LEN-1, else -> IDLE.
REQ-020 READ cycle outputs: A_dma = {src_hi, idx[7:0]}, rd_dma_n = 0.
- Di_dma is captured into the data latch at the end of the cycle.
REQ-021 WRITE cycle outputs: A_dma = DST_BASE + idx, Do_dma = latch, wr_dma_n = 0.
- idx increments at the end of the cycle.
REQ-022 idx is 8 bits wide; a transfer is exactly 2*DMA_LEN cycles (320 by default).
REQ-023 dma_active is high exactly while the state is not IDLE.
REQ-024 Strobe rules: never both strobes low in one cycle; both high in IDLE.
REQ-025 Register write while a transfer is active: src_hi is updated, idx resets to 0 and the FSM restarts at READ on the next cycle.
- A write and the final WRITE cycle on the same edge is treated as a restart.
REQ-026 Source values at or above 8'hE0 are used as-is; no address remapping is done.
REQ-027 Register access is decoded while dma_active is high; the CPU bus muxing is outside this block.

Reset
REQ-028 Reset, asynchronous, forces:
- state = IDLE, idx = 0, src_hi = 8'h00, data latch = 8'h00;
- A_dma = 0, Do_dma = 0;
- rd_dma_n = 1, wr_dma_n = 1, dma_active = 0, cpu_wait_n = 1.
REQ-029 Reset asserted mid-transfer aborts the transfer immediately; no further strobes until a new register write.

Configuration
REQ-030 Macro DMA_CPU_STALL_EN.
- Defined: cpu_wait_n = !dma_active, so the CPU is stalled for the whole transfer.
- Undefined: cpu_wait_n is tied to 1; the CPU runs and the system accepts that its non-HRAM bus accesses are lost during DMA.

Structure
REQ-031 A shared package holds:
- the FSM state encoding (2 bits);
- DMA_LEN and DST_BASE defaults;
- the REG_ADDR constant.
REQ-032 The block is a single module; no sub-module is needed.

Verification
REQ-033 Write 8'hC1 to FF46 -> dma_active is high on the next cycle; the first READ is at C100 and the first WRITE is at FE00.
REQ-034 Preload C100..C19F with i^8'h5A -> after 320 cycles FE00..FE9F match the source, dma_active falls and the bus stays idle.
REQ-035 Write 8'hC1 then, 50 cycles later, 8'hD0 -> idx resets; the next READ is D000 and the full 160 bytes are copied from D000.
REQ-036 Assert reset at cycle 100 of a transfer -> all outputs go to reset values asynchronously; no strobe until the next FF46 write.
REQ-037 Read FF46 after writing 8'h80 -> Do = 8'h80; a read at FF45 -> Do = 8'hFF.
REQ-038 With DMA_CPU_STALL_EN defined, cpu_wait_n is low for exactly 320 cycles; with it undefined, cpu_wait_n stays 1 throughout.
